// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter and sequencer sharing a single-port
//                256x8 memory between requester 0 (CPU core) and
//                requester 1 (loader/DMA/debug). Zero-cycle grant, bounded
//                burst locking, registered read data with a one-cycle
//                rvalid pulse per port.
//                Optional macro MEM_ARB_WRITE_PROT_EN: requester-1 writes
//                at or above PROT_BASE are granted but suppressed, and err1
//                pulses on the following cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter logic [7:0]  PROT_BASE = 8'hF0
) (
    input  logic       clk,
    input  logic       rst_n,
    // requester 0
    input  logic       req0,
    input  logic       we0,
    input  logic       lock0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    output logic       gnt0,
    output logic       rvalid0,
    output logic [7:0] rdata0,
    // requester 1
    input  logic       req1,
    input  logic       we1,
    input  logic       lock1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       gnt1,
    output logic       rvalid1,
    output logic [7:0] rdata1,
    output logic       err1,
    // memory side
    output logic       mem_wen,
    output logic [7:0] mem_address,
    output logic [7:0] mem_data_in,
    input  logic [7:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Locked grants allowed while burst_cnt is below this value; burst_cnt
    // starts at 0 on the first grant, so the owner gets MAX_BURST in a row.
    localparam logic [3:0] c_burst_lim = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       err1_q, err1_d;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_prot_blk;

    // Grant selection: lone requester always wins, contention resolved by
    // bounded lock hold and then round-robin against the last owner.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (req0 && !req1) begin
            w_gnt0 = 1'b1;
        end else if (req1 && !req0) begin
            w_gnt1 = 1'b1;
        end else if (req0 && req1) begin
            if (state_q == OWN0 && lock0 && burst_cnt_q < c_burst_lim) begin
                w_gnt0 = 1'b1;
            end else if (state_q == OWN1 && lock1 && burst_cnt_q < c_burst_lim) begin
                w_gnt1 = 1'b1;
            end else if (last_q) begin
                w_gnt0 = 1'b1;
            end else begin
                w_gnt1 = 1'b1;
            end
        end
        // No access may be issued while reset is held.
        if (!rst_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

`ifdef MEM_ARB_WRITE_PROT_EN
    assign w_prot_blk = w_gnt1 & we1 & (addr1 >= PROT_BASE);
`else
    // Protection disabled: the compare is masked so err1 and the write
    // enable are never affected.
    assign w_prot_blk = 1'b0 & (addr1 >= PROT_BASE);
`endif

    // Memory-side mux: granted port drives the bus, port 0 when idle.
    always_comb begin
        mem_address = addr0;
        mem_data_in = wdata0;
        mem_wen     = 1'b0;
        if (w_gnt1) begin
            mem_address = addr1;
            mem_data_in = wdata1;
            mem_wen     = we1 & ~w_prot_blk;
        end else if (w_gnt0) begin
            mem_wen     = we0;
        end
    end

    // Next-state, ownership history, burst counter and read capture.
    always_comb begin
        state_d     = IDLE;
        last_d      = last_q;
        burst_cnt_d = 4'd0;
        rvalid0_d   = w_gnt0 & ~we0;
        rvalid1_d   = w_gnt1 & ~we1;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        err1_d      = w_prot_blk;

        if (w_gnt0) begin
            state_d = OWN0;
            last_d  = 1'b0;
        end else if (w_gnt1) begin
            state_d = OWN1;
            last_d  = 1'b1;
        end

        if ((w_gnt0 && state_q == OWN0) || (w_gnt1 && state_q == OWN1)) begin
            burst_cnt_d = (burst_cnt_q == 4'd15) ? 4'd15 : burst_cnt_q + 4'd1;
        end

        if (w_gnt0 && !we0) begin
            rdata0_d = mem_data_out;
        end
        if (w_gnt1 && !we1) begin
            rdata1_d = mem_data_out;
        end
    end

    // State and output registers; reset makes port 0 win first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            burst_cnt_q <= 4'd0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= 8'h00;
            rdata1_q    <= 8'h00;
            err1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            err1_q      <= err1_d;
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign err1    = err1_q;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the CPU's single-port 256x8 memory. It shares the memory between requester 0 (CPU core) and requester 1 (loader/DMA/debug port) using round-robin arbitration with optional bounded burst locking. It drives the memory's address, write-enable and write-data inputs, and returns registered read data to each requester. It sits between the requesters and the `memory` instance in the top level.

## Interface
Parameters:
- MAX_BURST, 4: maximum consecutive locked grants to one owner while the other port requests; legal range 1..15.
- PROT_BASE, 8'hF0: lowest address write-protected against requester 1 (used only with the macro).

Ports (x = 0, 1; one set per requester):
- clk  in  1  clock; memory writes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- reqx  in  1  access request; hold with we/addr/wdata stable until gntx.
- wex  in  1  1 = write, 0 = read.
- lockx  in  1  request to keep ownership on following cycles.
- addrx  in  8  byte address.
- wdatax  in  8  write data.
- gntx  out  1  combinational; access performed this cycle.
- rvalidx  out  1  one-cycle pulse; rdatax valid.
- rdatax  out  8  registered read data.
- err1  out  1  one-cycle pulse; requester-1 write blocked (macro only, else tied 0).
- mem_wen  out  1  to memory wen.
- mem_address  out  8  to memory address.
- mem_data_in  out  8  to memory data_in.
- mem_data_out  in  8  from memory data_out (combinational read).

## Operation
- FSM states: IDLE (no grant last cycle), OWN0, OWN1 (grant to 0/1 last cycle). Next state = granted port, or IDLE if no grant.
- Registers: state, last (last granted port), burst_cnt[3:0], rvalidx, rdatax, err1.
- Grant selection, evaluated each cycle:
  - Only one req high → grant it.
  - Both high, state OWNx, lockx=1 and burst_cnt < MAX_BURST-1 → grant x (lock hold).
  - Both high otherwise → grant the port not equal to last.
  - Neither → no grant; mem_wen=0, mem_address/mem_data_in = port-0 values.
- burst_cnt: increments on a grant to the same port as the previous cycle, saturating at 15; cleared to 0 on owner change or IDLE. A lone requester is never forced off, whatever burst_cnt is.
- Mux: mem_address/mem_data_in come from the granted port; mem_wen = granted we (gated per Configuration).
- Read: on a granted read, mem_data_out is captured into rdatax at the closing edge; rvalidx pulses the next cycle. rdatax holds its value otherwise.
- A granted write completes at the closing edge; no rvalid is raised for writes.
- Exactly one gnt may be high in any cycle; gnt never asserts without the matching req.

## Timing
- Reset (rst_n low, async): state=IDLE, last=1 (port 0 wins first contention), burst_cnt=0, rvalidx=0, rdatax=8'h00, err1=0. gntx and mem_wen are forced 0 combinationally while rst_n is low.
- Grant latency: 0 cycles (gnt in the same cycle as req when selected). Read data latency: 1 cycle (rvalid on the cycle after gnt).
- Back-to-back: one access per cycle, fully pipelined; port x may request on the cycle its rvalid is high.
- Reset asserted mid-access: the write in flight is not guaranteed; pending rvalid is cleared; no stale pulse after release.
- Reset released: first grant no earlier than the first rising edge after deassertion.

## Configuration
- MEM_ARB_WRITE_PROT_EN defined: a requester-1 write to addr1 >= PROT_BASE is still granted (gnt1=1, so the handshake completes), but mem_wen=0 and err1 pulses the next cycle. Requester 0 is unrestricted.
- MEM_ARB_WRITE_PROT_EN undefined: no protection; err1 tied 0; PROT_BASE unused.

## Test plan
- Reset then single read: preload mem[8'h10]=8'hA5; req0 read 8'h10 → gnt0 same cycle; rvalid0=1, rdata0=8'hA5 next cycle; all outputs 0 during reset.
- Contention round-robin: req0 and req1 held high for 4 cycles (reads) → grants alternate 0,1,0,1.
- Lock bound (MAX_BURST=4): lock1=1, req1 and req0 continuously high, starting in OWN1 → gnt1 for 4 consecutive cycles, then gnt0; a lone req1 with lock stays granted indefinitely.
- Write/readback: req1 write 8'h3C to 8'h20, next cycle req0 read 8'h20 → rdata0=8'h3C, rvalid1 never pulses.
- Protection (macro on): req1 write 8'hFF to 8'hF4 → gnt1=1, mem_wen=0, err1 pulse, mem[8'hF4] unchanged; the same write from req0 succeeds. Macro off: the req1 write succeeds, err1=0.
- Async reset mid-read: assert rst_n low between gnt0 and the following cycle → rvalid0 never pulses; after release, port 0 wins the first contention.
